// File: rtl/sc_multi_port_ctrl_if.sv
// Port/grid bundle for the multi-port charging controller: per-port battery status
// and grid/ML inputs toward the controller, charge enables and status back out.
interface sc_multi_port_ctrl_if #(
  parameter int N_PORTS = 4
);
  localparam int AW = $clog2(N_PORTS + 1);

  logic [N_PORTS-1:0]   battery_connected;
  logic [N_PORTS-1:0]   battery_full;
  logic                 ml_predict_instability;
  logic [1:0]           grid_state;
  logic [N_PORTS-1:0]   charge_en;
  logic [2*N_PORTS-1:0] port_state;
  logic [AW-1:0]        active_count;
  logic                 safe_mode;
  logic                 ml_confirmed;

  modport master (
    output battery_connected, battery_full, ml_predict_instability, grid_state,
    input  charge_en, port_state, active_count, safe_mode, ml_confirmed
  );

  modport slave (
    input  battery_connected, battery_full, ml_predict_instability, grid_state,
    output charge_en, port_state, active_count, safe_mode, ml_confirmed
  );
endinterface

// File: rtl/sc_multi_port_ctrl.sv
// Smart-charging controller: per-port charge FSM, grid/ML-derived concurrency budget,
// round-robin grants with a dwell timeslice, and a safe mode with grid holdoff.
module sc_multi_port_ctrl #(
  parameter int N_PORTS             = 4,
  parameter int MAX_ACTIVE_STABLE   = 2,
  parameter int MAX_ACTIVE_DEGRADED = 1,
  parameter int HOLDOFF_CYCLES      = 16,
  parameter int DWELL_CYCLES        = 64,
  parameter int ML_CONFIRM          = 4
) (
  input logic                clk,
  input logic                reset_n,
  sc_multi_port_ctrl_if.slave bus
);
  localparam int AW = $clog2(N_PORTS + 1);
  localparam int PW = $clog2(N_PORTS);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int MW = $clog2(ML_CONFIRM + 1);
  localparam int DW = $clog2(DWELL_CYCLES);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_CHRG = 2'd2, ST_DONE = 2'd3} port_st_t;

  port_st_t          r_state     [N_PORTS];
  port_st_t          w_state_nxt [N_PORTS];
  logic [DW-1:0]     r_dwell     [N_PORTS];
  logic [PW-1:0]     r_rr;
  logic [PW-1:0]     w_rr_nxt;
  logic [HW-1:0]     r_hold;
  logic              r_safe;
  logic [MW-1:0]     r_ml_cnt;

  logic              w_unsafe;
  logic              w_ml_conf;
  logic              w_over;
  logic              w_any_wait;
  logic              w_grant_vld;
  logic [N_PORTS-1:0] w_grant;
  logic [AW-1:0]     w_active_cnt;
  int                w_budget;
  int                w_active;
  int                w_leave;
  int                w_ob_idx;
  int                w_dw_idx;
  int                w_grant_idx;
  int                w_best_d;
  int                w_d;

  assign w_unsafe  = bus.grid_state[1];
  assign w_ml_conf = (r_ml_cnt == MW'(ML_CONFIRM));

  always_comb begin
    w_budget = 0;
    if (r_safe || w_unsafe)          w_budget = 0;
    else if (bus.grid_state == 2'd0) w_budget = MAX_ACTIVE_STABLE;
    else                             w_budget = MAX_ACTIVE_DEGRADED;
    if (w_ml_conf && (w_budget > MAX_ACTIVE_DEGRADED)) w_budget = MAX_ACTIVE_DEGRADED;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PORTS; i++) r_state[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < N_PORTS; i++) r_state[i] <= w_state_nxt[i];
    end
  end

  // Next-state: revokes are resolved first so the grant sees the freed slots.
  always_comb begin
    w_state_nxt = r_state;
    w_active    = 0;
    w_any_wait  = 1'b0;
    w_leave     = 0;
    w_ob_idx    = -1;
    w_dw_idx    = -1;
    w_grant_vld = 1'b0;
    w_grant_idx = 0;
    w_best_d    = N_PORTS;
    w_d         = 0;
    w_grant     = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (r_state[i] == ST_CHRG) w_active = w_active + 1;
      if (r_state[i] == ST_WAIT) w_any_wait = 1'b1;
    end
    w_over = (w_active > w_budget);
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (r_state[i] == ST_CHRG) begin
        if (w_over) w_ob_idx = i;
        else if (w_any_wait && (r_dwell[i] == DW'(DWELL_CYCLES - 1))) w_dw_idx = i;
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (!bus.battery_connected[i])  w_state_nxt[i] = ST_IDLE;
      else if (bus.battery_full[i])   w_state_nxt[i] = ST_DONE;
      else begin
        case (r_state[i])
          ST_IDLE, ST_DONE: w_state_nxt[i] = ST_WAIT;
          ST_CHRG: if (w_unsafe || r_safe || (i == w_ob_idx) || (i == w_dw_idx))
                     w_state_nxt[i] = ST_WAIT;
          default: ;
        endcase
      end
      if ((r_state[i] == ST_CHRG) && (w_state_nxt[i] != ST_CHRG)) w_leave = w_leave + 1;
    end
    if (!w_over && ((w_active - w_leave) < w_budget)) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if ((r_state[i] == ST_WAIT) && bus.battery_connected[i] && !bus.battery_full[i]) begin
          w_d = i - int'(r_rr);
          if (w_d < 0) w_d = w_d + N_PORTS;
          if (w_d < w_best_d) begin
            w_best_d    = w_d;
            w_grant_idx = i;
            w_grant_vld = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      w_grant[i] = w_grant_vld && (w_grant_idx == i);
      if (w_grant[i]) w_state_nxt[i] = ST_CHRG;
    end
    w_rr_nxt = r_rr;
    if (w_grant_vld) w_rr_nxt = (w_grant_idx == N_PORTS - 1) ? '0 : PW'(w_grant_idx + 1);
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.port_state = '0;
    bus.charge_en  = '0;
    w_active_cnt   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      bus.port_state[2*i +: 2] = r_state[i];
      bus.charge_en[i]         = (r_state[i] == ST_CHRG);
      if (r_state[i] == ST_CHRG) w_active_cnt = w_active_cnt + AW'(1);
    end
    bus.active_count = w_active_cnt;
    bus.safe_mode    = r_safe;
    bus.ml_confirmed = w_ml_conf;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PORTS; i++) r_dwell[i] <= '0;
      r_rr     <= '0;
      r_hold   <= '0;
      r_safe   <= 1'b1;
      r_ml_cnt <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (w_grant[i]) r_dwell[i] <= '0;
        else if ((r_state[i] == ST_CHRG) && (r_dwell[i] != DW'(DWELL_CYCLES - 1)))
          r_dwell[i] <= r_dwell[i] + DW'(1);
      end
      r_rr <= w_rr_nxt;
      if (w_unsafe) begin
        r_hold <= '0;
        r_safe <= 1'b1;
      end else if (r_hold != HW'(HOLDOFF_CYCLES)) begin
        r_hold <= r_hold + HW'(1);
        r_safe <= (r_hold != HW'(HOLDOFF_CYCLES - 1));
      end else begin
        r_safe <= 1'b0;
      end
      if (!bus.ml_predict_instability) r_ml_cnt <= '0;
      else if (!w_ml_conf)             r_ml_cnt <= r_ml_cnt + MW'(1);
    end
  end
endmodule
